// File: rtl/avalon_mult_pkg.sv
// avalon_mult_pkg: register map, control bits and master FSM states shared by the multiplier bus blocks
package avalon_mult_pkg;
  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RES_LO = 3'd4;
  localparam logic [2:0] ADDR_RES_HI = 3'd5;
  localparam int CTRL_START_BIT   = 0;
  localparam int STATUS_READY_BIT = 0;
  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_GO, POLL_RD, POLL_WT, LO_RD, LO_WT, HI_RD, HI_WT, RESP
  } state_t;
endpackage

// File: rtl/avalon_mm_mult_master_if.sv
// avalon_mm_mult_master_if: command, response and Avalon-MM bus signals of the multiplier master
interface avalon_mm_mult_master_if #(parameter int SZ = 32);
  logic cmd_valid, cmd_ready;
  logic [SZ-1:0] cmd_a, cmd_b;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [2*SZ-1:0] rsp_res;
  logic [2:0] avm_address;
  logic avm_write, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_writedata, avm_readdata;
  modport master (
    input cmd_valid, cmd_a, cmd_b, rsp_ready, avm_readdata, avm_waitrequest, avm_readdatavalid,
    output cmd_ready, rsp_valid, rsp_err, rsp_res, avm_address, avm_write, avm_read, avm_writedata
  );
  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, avm_readdata, avm_waitrequest, avm_readdatavalid,
    input cmd_ready, rsp_valid, rsp_err, rsp_res, avm_address, avm_write, avm_read, avm_writedata
  );
endinterface

// File: rtl/avmm_single_xfer.sv
// avmm_single_xfer: runs one Avalon-MM read or write; done is combinational on the completing cycle
module avmm_single_xfer (
  input  logic        clk,
  input  logic        _rst,
  input  logic        start,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        acc,
  output logic        done,
  output logic [31:0] rdata,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);
  logic pend;
  assign acc = (avm_write || avm_read) && !avm_waitrequest;
  assign done = (avm_write && !avm_waitrequest) || (pend && avm_readdatavalid);
  assign rdata = avm_readdata;
  // request held until accepted; a new start on the completing edge chains transfers back to back
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      avm_write <= 1'b0;
      avm_read <= 1'b0;
      avm_address <= '0;
      avm_writedata <= '0;
      pend <= 1'b0;
    end else begin
      if (start) begin
        avm_write <= wr;
        avm_read <= !wr;
        avm_address <= addr;
        avm_writedata <= wdata;
      end else if (acc) begin
        avm_write <= 1'b0;
        avm_read <= 1'b0;
      end
      pend <= pend ? !avm_readdatavalid : (avm_read && !avm_waitrequest);
    end
endmodule

// File: rtl/avalon_mm_mult_master.sv
// avalon_mm_mult_master: drives the multiplier register map for one operand pair per command
module avalon_mm_mult_master
  import avalon_mult_pkg::*;
#(
  parameter int SZ = 32,
  parameter int POLL_MAX = 1024
) (
  input logic clk,
  input logic _rst,
  avalon_mm_mult_master_if.master m
);
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam logic [CW-1:0] PMAX = CW'(POLL_MAX);
  state_t state;
  logic [SZ-1:0] b_q, lo_q;
  logic [CW-1:0] cnt;
  logic go, wr, acc, done, ready_bit;
  logic [2:0] addr;
  logic [31:0] wdata, rdata;
  assign ready_bit = rdata[STATUS_READY_BIT];
  // next transfer, launched on the same edge that finishes the current one
  always_comb begin
    go = 1'b0;
    wr = 1'b1;
    addr = ADDR_A;
    wdata = '0;
    case (state)
      IDLE:    begin go = m.cmd_valid; wdata = 32'(m.cmd_a); end
      WR_A:    begin go = done; addr = ADDR_B; wdata = 32'(b_q); end
      WR_B:    begin go = done; addr = ADDR_CTRL; wdata = 32'd1 << CTRL_START_BIT; end
      WR_GO:   begin go = done; wr = 1'b0; addr = ADDR_STATUS; end
      POLL_WT: begin go = done && (ready_bit || cnt != PMAX); wr = 1'b0; addr = ready_bit ? ADDR_RES_LO : ADDR_STATUS; end
      LO_WT:   begin go = done; wr = 1'b0; addr = ADDR_RES_HI; end
      default: ;
    endcase
  end
  avmm_single_xfer u_xfer (
    .clk(clk), ._rst(_rst), .start(go), .wr(wr), .addr(addr), .wdata(wdata),
    .acc(acc), .done(done), .rdata(rdata),
    .avm_address(m.avm_address), .avm_write(m.avm_write), .avm_read(m.avm_read),
    .avm_writedata(m.avm_writedata), .avm_readdata(m.avm_readdata),
    .avm_waitrequest(m.avm_waitrequest), .avm_readdatavalid(m.avm_readdatavalid)
  );
  // command sequencer with registered handshake and result outputs
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      state <= IDLE;
      m.cmd_ready <= 1'b1;
      m.rsp_valid <= 1'b0;
      m.rsp_err <= 1'b0;
      m.rsp_res <= '0;
      b_q <= '0;
      lo_q <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (m.cmd_valid) begin
          state <= WR_A;
          m.cmd_ready <= 1'b0;
          b_q <= m.cmd_b;
          cnt <= '0;
        end
        WR_A:    if (done) state <= WR_B;
        WR_B:    if (done) state <= WR_GO;
        WR_GO:   if (done) state <= POLL_RD;
        POLL_RD: if (acc) begin state <= POLL_WT; cnt <= cnt + 1'b1; end
        POLL_WT: if (done) begin
          if (ready_bit) state <= LO_RD;
          else if (cnt == PMAX) begin
            state <= RESP;
            m.rsp_valid <= 1'b1;
            m.rsp_err <= 1'b1;
            m.rsp_res <= '0;
          end else state <= POLL_RD;
        end
        LO_RD:   if (acc) state <= LO_WT;
        LO_WT:   if (done) begin state <= HI_RD; lo_q <= rdata[SZ-1:0]; end
        HI_RD:   if (acc) state <= HI_WT;
        HI_WT:   if (done) begin
          state <= RESP;
          m.rsp_valid <= 1'b1;
          m.rsp_err <= 1'b0;
          m.rsp_res <= {rdata[SZ-1:0], lo_q};
        end
        RESP:    if (m.rsp_ready) begin
          state <= IDLE;
          m.rsp_valid <= 1'b0;
          m.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_avalon_mm_mult_master.sv
// tb_avalon_mm_mult_master: directed and random commands against a behavioural multiplier slave
module tb_avalon_mm_mult_master;
  logic clk = 1'b0;
  logic rst_n, cv, rsp_ready, sel;
  logic [31:0] ca, cb;
  logic [31:0] s_rdata = '0;
  logic s_wreq = 1'b0, s_rdv = 1'b0;
  int errors = 0, checks = 0, stab_err = 0;
  int waits [8];
  int ready_after;
  int tr_addr [$];
  logic [31:0] tr_data [$];
  always #5 clk = ~clk;

  avalon_mm_mult_master_if #(.SZ(32)) ifa ();
  avalon_mm_mult_master_if #(.SZ(32)) ifb ();
  avalon_mm_mult_master #(.SZ(32), .POLL_MAX(1024)) dut0 (.clk(clk), ._rst(rst_n), .m(ifa));
  avalon_mm_mult_master #(.SZ(32), .POLL_MAX(2)) dut1 (.clk(clk), ._rst(rst_n), .m(ifb));

  assign ifa.cmd_valid = cv & ~sel;
  assign ifb.cmd_valid = cv & sel;
  assign ifa.cmd_a = ca;
  assign ifb.cmd_a = ca;
  assign ifa.cmd_b = cb;
  assign ifb.cmd_b = cb;
  assign ifa.rsp_ready = rsp_ready;
  assign ifb.rsp_ready = rsp_ready;
  assign ifa.avm_readdata = s_rdata;
  assign ifb.avm_readdata = s_rdata;
  assign ifa.avm_waitrequest = s_wreq;
  assign ifb.avm_waitrequest = s_wreq;
  assign ifa.avm_readdatavalid = s_rdv;
  assign ifb.avm_readdatavalid = s_rdv;

  logic o_cmd_ready, o_rsp_valid, o_rsp_err, m_write, m_read;
  logic [63:0] o_rsp_res;
  logic [2:0] m_addr;
  logic [31:0] m_wdata;
  assign o_cmd_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign o_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_rsp_err = sel ? ifb.rsp_err : ifa.rsp_err;
  assign o_rsp_res = sel ? ifb.rsp_res : ifa.rsp_res;
  assign m_write = sel ? ifb.avm_write : ifa.avm_write;
  assign m_read = sel ? ifb.avm_read : ifa.avm_read;
  assign m_addr = sel ? ifb.avm_address : ifa.avm_address;
  assign m_wdata = sel ? ifb.avm_writedata : ifa.avm_writedata;

  bit in_xfer = 1'b0, h_w = 1'b0, rd_due = 1'b0;
  int rem = 0, polls = 0;
  logic [2:0] h_addr = '0;
  logic [31:0] h_data = '0, rd_val = '0, ra = '0, rb = '0;
  logic [63:0] prod = '0;

  // slave model: decides waitrequest and read data at the falling edge, accepted on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer = 1'b0; rem = 0; rd_due = 1'b0; polls = 0;
      s_wreq = 1'b0; s_rdv = 1'b0;
    end else begin
      s_rdv = rd_due;
      s_rdata = rd_val;
      rd_due = 1'b0;
      if (m_write || m_read) begin
        if (!in_xfer) begin
          in_xfer = 1'b1; rem = waits[m_addr]; h_addr = m_addr; h_data = m_wdata; h_w = m_write;
        end else if (m_addr !== h_addr || m_wdata !== h_data || m_write !== h_w) stab_err++;
        if (rem > 0) begin
          s_wreq = 1'b1;
          rem--;
        end else begin
          s_wreq = 1'b0;
          in_xfer = 1'b0;
          tr_addr.push_back(int'(m_addr));
          tr_data.push_back(m_write ? m_wdata : 32'd0);
          if (m_write) begin
            if (m_addr == 3'd0) ra = m_wdata;
            if (m_addr == 3'd1) rb = m_wdata;
            if (m_addr == 3'd2 && m_wdata[0]) begin prod = {32'b0, ra} * {32'b0, rb}; polls = 0; end
          end else begin
            rd_due = 1'b1;
            if (m_addr == 3'd3) polls++;
            rd_val = m_addr == 3'd3 ? {31'b0, ready_after != 0 && polls >= ready_after} :
                     m_addr == 3'd4 ? prod[31:0] : m_addr == 3'd5 ? prod[63:32] : 32'd0;
          end
        end
      end else begin
        s_wreq = 1'b0;
        if (in_xfer) stab_err++;
        in_xfer = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"}, 64'({o_cmd_ready, o_rsp_valid, o_rsp_err, m_write, m_read}), 64'b10000);
    chk({tag, "_addr"}, 64'(m_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(m_wdata), 64'd0);
    chk({tag, "_res"}, o_rsp_res, 64'd0);
  endtask

  function automatic int status_reads(input int base);
    int c = 0;
    for (int i = base; i < tr_addr.size(); i++) if (tr_addr[i] == 3) c++;
    return c;
  endfunction

  task automatic chk_trace(input int base, input int np, input bit err, input logic [31:0] a, input logic [31:0] b);
    int ea [$];
    logic [31:0] ed [3];
    ea = '{0, 1, 2};
    ed = '{a, b, 32'd1};
    for (int i = 0; i < np; i++) ea.push_back(3);
    if (!err) begin ea.push_back(4); ea.push_back(5); end
    chk("trace_len", 64'(tr_addr.size() - base), 64'(ea.size()));
    for (int i = 0; i < ea.size() && base + i < tr_addr.size(); i++) begin
      chk("trace_addr", 64'(tr_addr[base + i]), 64'(ea[i]));
      if (i < 3) chk("trace_wdata", 64'(tr_data[base + i]), 64'(ed[i]));
    end
  endtask

  task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input int np, input bit err, input bit hold);
    int base, n, exp_lat;
    logic [63:0] exp_res;
    base = tr_addr.size();
    exp_res = err ? 64'd0 : {32'b0, a} * {32'b0, b};
    exp_lat = 4 + waits[0] + waits[1] + waits[2] + np * (waits[3] + 2) + (err ? 0 : waits[4] + waits[5] + 4);
    rsp_ready = !hold;
    chk("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
    cv = 1'b1; ca = a; cb = b;
    @(posedge clk); #1 cv = 1'b0;
    n = 1;
    while (o_rsp_valid !== 1'b1 && n < 400) begin @(posedge clk); #1 n++; end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("rsp_res", o_rsp_res, exp_res);
    chk("rsp_err", 64'(o_rsp_err), 64'(err));
    if (hold) begin
      cv = 1'b1; ca = ~a;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("hold_flags", 64'({o_rsp_valid, o_cmd_ready}), 64'b10);
        chk("hold_res", o_rsp_res, exp_res);
      end
      cv = 1'b0; rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_done_idle", 64'({o_rsp_valid, o_cmd_ready}), 64'b01);
    chk_trace(base, np, err, a, b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, sz;
    rst_n = 1'b0; cv = 1'b0; rsp_ready = 1'b1; sel = 1'b0; ca = '0; cb = '0;
    foreach (waits[j]) waits[j] = 0;
    ready_after = 1;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(32'd3, 32'd5, 1, 1'b0, 1'b0);
    do_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    waits[1] = 3; waits[4] = 3;
    do_cmd(32'h0001_2345, 32'h0ABC_DEF1, 1, 1'b0, 1'b0);
    chk("bus_stable_wait", 64'(stab_err), 64'd0);
    waits[1] = 0; waits[4] = 0;
    ready_after = 4;
    do_cmd(32'd1000, 32'd77, 4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      foreach (waits[j]) waits[j] = $urandom_range(2);
      ready_after = $urandom_range(3, 1);
      do_cmd($urandom, $urandom, ready_after, 1'b0, 1'b0);
    end
    chk("bus_stable_rand", 64'(stab_err), 64'd0);
    foreach (waits[j]) waits[j] = 0;
    ready_after = 1;
    do_cmd(32'h8000_0001, 32'd3, 1, 1'b0, 1'b1);
    sz = tr_addr.size();
    repeat (3) @(posedge clk);
    #1 chk("no_accept_after_hold", 64'({tr_addr.size() != sz, m_write, m_read}), 64'd0);
    sel = 1'b1; ready_after = 0;
    do_cmd(32'h1234, 32'h5678, 2, 1'b1, 1'b0);
    sel = 1'b0;
    base = tr_addr.size();
    cv = 1'b1; ca = 32'd9; cb = 32'd9;
    @(posedge clk); #1 cv = 1'b0;
    n = 0;
    while (!(status_reads(base) >= 2 && m_read === 1'b0) && n < 200) begin @(posedge clk); #1 n++; end
    chk("reach_poll_wt", 64'(n < 200), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1 chk("no_rsp_in_reset", 64'(o_rsp_valid), 64'd0);
    rst_n = 1'b1;
    ready_after = 1;
    @(posedge clk); #1;
    do_cmd(32'd7, 32'd6, 1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
